// File: rtl/sa_cache_pkg.sv
// Shared types and geometry helpers for the set-associative cache.
package sa_cache_pkg;
    typedef enum logic [1:0] {IDLE, FILL, DONE, INVAL} state_t;

    function automatic int off_w(int words, int data_w);
        return $clog2(words * data_w / 8);
    endfunction

    function automatic int idx_w(int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(int addr_w, int words, int data_w, int sets);
        return addr_w - off_w(words, data_w) - idx_w(sets);
    endfunction
endpackage

// File: rtl/sa_cache_way.sv
// One cache way: tag, valid and line data storage with async read and sync write.
module sa_cache_way #(
    parameter int DATA_W = 16,
    parameter int WORDS  = 8,
    parameter int SETS   = 64,
    parameter int TAG_W  = 6,
    localparam int IDX_W  = $clog2(SETS),
    localparam int WSEL_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [WSEL_W-1:0] rd_word,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              data_we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WSEL_W-1:0] wr_word,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              clr,
    input  logic [IDX_W-1:0]  clr_idx
);
    logic [DATA_W-1:0] mem  [SETS*WORDS];
    logic [TAG_W-1:0]  tags [SETS];
    logic [SETS-1:0]   valid;

    assign rd_data  = mem[{rd_idx, rd_word}];
    assign rd_tag   = tags[rd_idx];
    assign rd_valid = valid[rd_idx];

    always_ff @(posedge clk) begin
        if (data_we) mem[{wr_idx, wr_word}] <= wr_data;
        if (tag_we)  tags[wr_idx] <= wr_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      valid <= '0;
        else if (clr)    valid[clr_idx] <= 1'b0;
        else if (tag_we) valid[wr_idx] <= 1'b1;
    end
endmodule

// File: rtl/sa_cache.sv
// Write-through, no-write-allocate N-way cache with LRU, pipelined line fill,
// invalidate sweep and saturating hit/miss counters.
module sa_cache
    import sa_cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8,
    parameter int SETS   = 64,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_rd,
    input  logic              pipe_wr,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    input  logic              inv_req,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    localparam int OFF_W  = off_w(WORDS, DATA_W);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, WORDS, DATA_W, SETS);
    localparam int BB     = $clog2(DATA_W / 8);
    localparam int WSEL_W = $clog2(WORDS);
    localparam int CNT_W  = WSEL_W + 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t state, state_nx;
    logic [IDX_W-1:0]  p_idx, f_idx, inv_cnt, wr_idx;
    logic [TAG_W-1:0]  p_tag, f_tag;
    logic [WSEL_W-1:0] p_word, wr_word;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  iss_cnt, rcv_cnt;
    logic [WAY_W-1:0]  victim, vic_nx, hit_way;
    logic [SETS-1:0]   lru;
    logic              inv_pend, hit, idle, fill, rd_req, rd_miss, svc_hit;
    logic              unused_lsb;

    logic [WAYS-1:0]             w_valid, dwe;
    logic [WAYS-1:0][TAG_W-1:0]  w_tag;
    logic [WAYS-1:0][DATA_W-1:0] w_data;

    assign p_idx      = pipe_addr[OFF_W +: IDX_W];
    assign p_tag      = pipe_addr[ADDR_W-1 -: TAG_W];
    assign p_word     = pipe_addr[BB +: WSEL_W];
    assign unused_lsb = pipe_addr[0];

    assign idle    = (state == IDLE);
    assign fill    = (state == FILL);
    assign rd_req  = pipe_rd & ~pipe_wr;
    assign rd_miss = idle & rd_req & ~hit;
    assign svc_hit = idle & (pipe_wr | rd_req) & hit;

    assign stall     = ~idle | rd_miss;
    assign rd_data   = (idle & rd_req & hit) ? w_data[hit_way] : '0;
    assign mem_we    = idle & pipe_wr;
    assign mem_wdata = pipe_wdata;
    assign mem_re    = fill & (iss_cnt < CNT_W'(WORDS));
    assign mem_addr  = fill ? ({f_tag, f_idx, {OFF_W{1'b0}}} + (ADDR_W'(iss_cnt[WSEL_W-1:0]) << BB))
                            : pipe_addr;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (w_valid[w] && w_tag[w] == p_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
    end

    // Lowest invalid way wins; otherwise the set's LRU way is replaced.
    always_comb begin
        vic_nx = (WAYS > 1) ? WAY_W'(lru[p_idx]) : '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!w_valid[w]) vic_nx = WAY_W'(w);
    end

    always_comb begin
        wr_idx  = idle ? p_idx : f_idx;
        wr_word = idle ? p_word : rcv_cnt[WSEL_W-1:0];
        wr_data = idle ? pipe_wdata : mem_rdata;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rd_miss) state_nx = FILL;
                     else if (inv_req | inv_pend) state_nx = INVAL;
            FILL:    if (mem_rvalid && rcv_cnt == CNT_W'(WORDS - 1)) state_nx = DONE;
            DONE:    state_nx = (inv_req | inv_pend) ? INVAL : IDLE;
            INVAL:   if (inv_cnt == IDX_W'(SETS - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            iss_cnt  <= '0;
            rcv_cnt  <= '0;
            inv_cnt  <= '0;
            inv_pend <= 1'b0;
            f_idx    <= '0;
            f_tag    <= '0;
            victim   <= '0;
            lru      <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state <= state_nx;
            if (rd_miss) begin
                f_idx   <= p_idx;
                f_tag   <= p_tag;
                victim  <= vic_nx;
                iss_cnt <= '0;
                rcv_cnt <= '0;
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
            if (fill) begin
                if (mem_re)     iss_cnt <= iss_cnt + 1'b1;
                if (mem_rvalid) rcv_cnt <= rcv_cnt + 1'b1;
            end
            // A request arriving mid-fill is remembered and swept once DONE retires.
            if (state_nx == INVAL)                 inv_pend <= 1'b0;
            else if (inv_req && state != INVAL)    inv_pend <= 1'b1;
            if (state == INVAL) inv_cnt <= inv_cnt + 1'b1;
            if (state == INVAL)      lru[inv_cnt] <= 1'b0;
            else if (svc_hit)        lru[p_idx]   <= ~hit_way[0];
            else if (state == DONE)  lru[f_idx]   <= ~victim[0];
            if (svc_hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign dwe[w] = (svc_hit & pipe_wr & (hit_way == WAY_W'(w)))
                      | (fill & mem_rvalid & (victim == WAY_W'(w)));

        sa_cache_way #(
            .DATA_W(DATA_W), .WORDS(WORDS), .SETS(SETS), .TAG_W(TAG_W)
        ) u_way (
            .clk     (clk),
            .rst_n   (rst_n),
            .rd_idx  (p_idx),
            .rd_word (p_word),
            .rd_tag  (w_tag[w]),
            .rd_valid(w_valid[w]),
            .rd_data (w_data[w]),
            .data_we (dwe[w]),
            .wr_idx  (wr_idx),
            .wr_word (wr_word),
            .wr_data (wr_data),
            .tag_we  ((state == DONE) && (victim == WAY_W'(w))),
            .wr_tag  (f_tag),
            .clr     (state == INVAL),
            .clr_idx (inv_cnt)
        );
    end
endmodule
